// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage unit for the RV32I core. Base integer ops finish
// in one cycle; RV32M multiply/divide ops run an iterative radix-2 engine
// for XLEN cycles. Results and compare flags leave on a valid/ready channel.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; op, a, b latched on accept
//   op[4:0]               op[4]=0 base ALU op, op[4]=1 M-extension op
//   a, b                  operands (rs1, rs2/imm)
//   out_valid / out_ready output handshake
//   result                registered result
//   zero                  result == 0
//   less, lessu           signed / unsigned a < b of the accepted op
//   busy                  M-op iteration in progress
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            less,
    output logic            lessu,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] LastIter = (SHW+1)'(XLEN-1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [SHW:0]        r_count;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_operand;
    logic [XLEN-1:0]     r_result;
    logic [2:0]          r_func;
    logic                r_negRes;
    logic                r_negRem;
    logic                r_divZero;
    logic                r_less;
    logic                r_lessu;

    logic                w_accept;
    logic                w_isIter;
    logic                w_lastIter;
    logic                w_less;
    logic                w_lessu;
    logic [XLEN-1:0]     w_aluRes;
    logic                w_aSigned;
    logic                w_bSigned;
    logic                w_negA;
    logic                w_negB;
    logic [XLEN-1:0]     w_magA;
    logic [XLEN-1:0]     w_magB;
    logic [XLEN:0]       w_mulSum;
    logic [XLEN:0]       w_divRem;
    logic [XLEN:0]       w_divDiff;
    logic [2*XLEN-1:0]   w_accNext;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_mResult;

    // Only M ops with op[3]=0 iterate; op[3]=1 M codes complete like base ops.
    assign w_accept   = in_valid & in_ready;
    assign w_isIter   = op[4] & ~op[3];
    assign w_lastIter = (r_count == LastIter);
    assign w_less     = $signed(a) < $signed(b);
    assign w_lessu    = a < b;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and handshake outputs. A stalled DONE refuses new input.
    always_comb begin
        w_stateNext = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_stateNext = w_isIter ? BUSY : DONE;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (w_lastIter) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_stateNext = w_isIter ? BUSY : DONE;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Single-cycle base ALU; unused codes and op[4]=1 codes give 0.
    always_comb begin
        w_aluRes = '0;
        if (!op[4]) begin
            case (op[3:0])
                4'b0000: w_aluRes = a + b;
                4'b0001: w_aluRes = {{(XLEN-1){1'b0}}, w_less};
                4'b0010: w_aluRes = {{(XLEN-1){1'b0}}, w_lessu};
                4'b0011: w_aluRes = a ^ b;
                4'b0100: w_aluRes = a | b;
                4'b0111: w_aluRes = a & b;
                4'b1000: w_aluRes = a << b[SHW-1:0];
                4'b1001: w_aluRes = a >> b[SHW-1:0];
                4'b1010: w_aluRes = $signed(a) >>> b[SHW-1:0];
                4'b1011: w_aluRes = a - b;
                default: w_aluRes = '0;
            endcase
        end
    end

    // Operand signedness per M function; the engine works on magnitudes.
    assign w_aSigned = (op[2:0] == 3'b001) | (op[2:0] == 3'b010) |
                       (op[2:0] == 3'b100) | (op[2:0] == 3'b110);
    assign w_bSigned = (op[2:0] == 3'b001) | (op[2:0] == 3'b100) |
                       (op[2:0] == 3'b110);
    assign w_negA    = w_aSigned & a[XLEN-1];
    assign w_negB    = w_bSigned & b[XLEN-1];
    assign w_magA    = w_negA ? (~a + XLEN'(1)) : a;
    assign w_magB    = w_negB ? (~b + XLEN'(1)) : b;

    // Multiply: upper half accumulates, lower half holds the multiplier and
    // shifts out one bit per step. Divide: {remainder, quotient} pair with a
    // trial subtract on XLEN+1 bits; the quotient bit enters at the bottom.
    assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                       (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_divRem  = r_acc[2*XLEN-1:XLEN-1];
    assign w_divDiff = w_divRem - {1'b0, r_operand};

    always_comb begin
        w_accNext = {w_mulSum, r_acc[XLEN-1:1]};
        if (r_func[2]) begin
            if (!w_divDiff[XLEN]) begin
                w_accNext = {w_divDiff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_accNext = {w_divRem[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up on the final step. A zero divisor forces an all-ones
    // quotient; its remainder naturally comes out as the dividend.
    assign w_prod = r_negRes ? (~w_accNext + (2*XLEN)'(1)) : w_accNext;
    assign w_quot = r_divZero ? '1 :
                    (r_negRes ? (~w_accNext[XLEN-1:0] + XLEN'(1)) : w_accNext[XLEN-1:0]);
    assign w_rem  = r_negRem ? (~w_accNext[2*XLEN-1:XLEN] + XLEN'(1))
                             : w_accNext[2*XLEN-1:XLEN];

    always_comb begin
        case (r_func)
            3'b000:                 w_mResult = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_mResult = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_mResult = w_quot;
            default:                w_mResult = w_rem;
        endcase
    end

    // Datapath: latch flags and operands on accept, iterate while BUSY,
    // write the M result on the last iteration. Result holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_less    <= 1'b0;
            r_lessu   <= 1'b0;
            r_acc     <= '0;
            r_operand <= '0;
            r_func    <= '0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_less  <= w_less;
            r_lessu <= w_lessu;
            if (w_isIter) begin
                r_func    <= op[2:0];
                r_negRes  <= w_negA ^ w_negB;
                r_negRem  <= w_negA;
                r_divZero <= (b == '0);
                r_count   <= '0;
                if (op[2]) begin
                    r_acc     <= {{XLEN{1'b0}}, w_magA};
                    r_operand <= w_magB;
                end else begin
                    r_acc     <= {{XLEN{1'b0}}, w_magB};
                    r_operand <= w_magA;
                end
            end else begin
                r_result <= w_aluRes;
            end
        end else if (r_state == BUSY) begin
            r_acc <= w_accNext;
            if (w_lastIter) begin
                r_count  <= '0;
                r_result <= w_mResult;
            end else begin
                r_count <= r_count + (SHW+1)'(1);
            end
        end
    end

    assign result = r_result;
    assign zero   = (r_result == '0);
    assign less   = r_less;
    assign lessu  = r_lessu;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed testbench for alu_mdu. A reference model computes
// each op's result, flags and completion time from plain arithmetic and a
// checker compares the DUT to it on every cycle; directed runs also pin
// results and latencies to hand-computed constants. A second XLEN=16
// instance covers the narrow build.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        less;
    logic        lessu;
    logic        busy;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [4:0]  op16 = '0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] result16;
    logic        zero16;
    logic        less16;
    logic        lessu16;
    logic        busy16;

    int nTests = 0;
    int nFail = 0;

    // Reference model state
    int          cyc = 0;
    bit          mdlPending = 1'b0;
    bit          mdlAccept = 1'b0;
    int          mdlValidAt = 0;
    int          mdlTaken = 0;
    int          outTaken = 0;
    logic [31:0] mdlRes = '0;
    bit          mdlLess = 1'b0;
    bit          mdlLessu = 1'b0;
    bit          checkEn = 1'b0;
    bit          expValid;
    bit          lastZero, lastLess, lastLessu;

    localparam logic [4:0] ADD = 5'b00000, SLT = 5'b00001, SLTU = 5'b00010,
                           XOR = 5'b00011, OR = 5'b00100, AND = 5'b00111,
                           SLL = 5'b01000, SRL = 5'b01001, SRA = 5'b01010,
                           SUB = 5'b01011, MUL = 5'b10000, MULH = 5'b10001,
                           MULHSU = 5'b10010, MULHU = 5'b10011, DIV = 5'b10100,
                           DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .less(less), .lessu(lessu), .busy(busy)
    );

    alu_mdu #(.XLEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .zero(zero16), .less(less16), .lessu(lessu16), .busy(busy16)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one op, from plain integer arithmetic.
    function automatic logic [31:0] golden(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        golden = '0;
        if (!o[4]) begin
            case (o[3:0])
                4'd0:  golden = x + y;
                4'd1:  golden = {31'b0, ($signed(x) < $signed(y))};
                4'd2:  golden = {31'b0, (x < y)};
                4'd3:  golden = x ^ y;
                4'd4:  golden = x | y;
                4'd7:  golden = x & y;
                4'd8:  golden = x << y[4:0];
                4'd9:  golden = x >> y[4:0];
                4'd10: golden = $signed(x) >>> y[4:0];
                4'd11: golden = x - y;
                default: golden = '0;
            endcase
        end else if (!o[3]) begin
            case (o[2:0])
                3'd0: begin p = 64'(sx * sy); golden = p[31:0]; end
                3'd1: begin p = 64'(sx * sy); golden = p[63:32]; end
                3'd2: begin p = 64'(sx * longint'({32'b0, y})); golden = p[63:32]; end
                3'd3: begin p = {32'b0, x} * {32'b0, y}; golden = p[63:32]; end
                3'd4: golden = (y == 0) ? 32'hFFFFFFFF : 32'(sx / sy);
                3'd5: golden = (y == 0) ? 32'hFFFFFFFF : x / y;
                3'd6: golden = (y == 0) ? x : 32'(sx % sy);
                default: golden = (y == 0) ? x : x % y;
            endcase
        end
    endfunction

    // Model: tracks one outstanding op and the edge its output appears after.
    always @(posedge clk or negedge rst_n) begin
        bit preValid, preReady;
        if (!rst_n) begin
            mdlPending = 1'b0;
            mdlAccept  = 1'b0;
        end else begin
            preValid  = mdlPending && (cyc >= mdlValidAt);
            preReady  = !mdlPending || (preValid && out_ready);
            mdlAccept = in_valid && preReady;
            cyc++;
            if (preValid && out_ready) begin
                mdlPending = 1'b0;
                mdlTaken++;
            end
            if (mdlAccept) begin
                mdlPending = 1'b1;
                mdlRes     = golden(op, a, b);
                mdlLess    = $signed(a) < $signed(b);
                mdlLessu   = a < b;
                mdlValidAt = (op[4] && !op[3]) ? cyc + 32 : cyc;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (rst_n && checkEn) begin
            expValid = mdlPending && (cyc >= mdlValidAt);
            checkOutput("out_valid", out_valid, expValid);
            checkOutput("in_ready", in_ready, !mdlPending || (expValid && out_ready));
            checkOutput("busy", busy, mdlPending && !expValid);
            if (expValid) begin
                checkOutput("result", result, mdlRes);
                checkOutput("zero", zero, mdlRes == 0);
                checkOutput("less", less, mdlLess);
                checkOutput("lessu", lessu, mdlLessu);
            end
            if (out_valid && out_ready) outTaken++;
        end
    end

    // Present one op and hold it until the model says it was accepted.
    task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int guard;
        guard = 0;
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        while (!mdlAccept && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!mdlAccept) checkOutput("accept timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] expRes, input int expLat);
        int lat;
        lat = 1;
        applyStimulus(o, x, y);
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput(name, result, expRes);
        checkOutput({name, " latency"}, lat, expLat);
        lastZero = zero; lastLess = less; lastLessu = lessu;
        @(posedge clk); #1;
    endtask

    task automatic runOp16(input string name, input logic [4:0] o, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] expRes, input int expLat);
        int lat;
        lat = 1;
        checkOutput({name, " in_ready"}, in_ready16, 1);
        op16 = o; a16 = x; b16 = y; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        @(negedge clk);
        while (!out_valid16 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput(name, result16, expRes);
        checkOutput({name, " latency"}, lat, expLat);
        @(posedge clk); #1;
    endtask

    task automatic checkReset();
        checkOutput("rst in_ready", in_ready, 1);
        checkOutput("rst out_valid", out_valid, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst result", result, 0);
        checkOutput("rst zero", zero, 1);
        checkOutput("rst less", less, 0);
        checkOutput("rst lessu", lessu, 0);
    endtask

    initial begin
        // Hand-computed pins on the model itself
        checkOutput("model MULHU", golden(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
        checkOutput("model REM", golden(REM, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
        checkOutput("model DIVovf", golden(DIV, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);

        repeat (2) @(posedge clk);
        #1 checkReset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkEn = 1'b1;

        runOp("ADD wrap", ADD, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1);
        checkOutput("ADD zero", lastZero, 1);
        checkOutput("ADD less", lastLess, 1);
        checkOutput("ADD lessu", lastLessu, 0);
        runOp("SRA", SRA, 32'h80000000, 32'h21, 32'hC0000000, 1);
        runOp("SUB", SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
        runOp("SLT", SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
        runOp("SLTU", SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
        runOp("XOR", XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
        runOp("OR", OR, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1);
        runOp("AND", AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
        runOp("SLL", SLL, 32'h00000003, 32'h00000024, 32'h00000030, 1);
        runOp("SRL", SRL, 32'h80000000, 32'd31, 32'h00000001, 1);
        runOp("unused op", 5'b00101, 32'd9, 32'd9, 32'd0, 1);
        runOp("MUL", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        runOp("MULH", MULH, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        runOp("MULHSU", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        runOp("MULHU", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        runOp("DIV", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        runOp("REM", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        runOp("DIVU by 0", DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 33);
        runOp("REM by 0", REM, 32'd5, 32'd0, 32'd5, 33);
        runOp("DIV ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        runOp("REM ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
        runOp("DIVU", DIVU, 32'd100, 32'd7, 32'd14, 33);
        runOp("REMU", REMU, 32'd100, 32'd7, 32'd2, 33);
        runOp("M op3", 5'b11000, 32'd3, 32'd4, 32'd0, 1);

        // Streamed ADDs against a toggling consumer
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus(ADD, 32'(i * 3 + 1), 32'd10);
            end
            begin
                out_ready = 1'b1; @(posedge clk); #1;
                out_ready = 1'b0; @(posedge clk); #1;
                out_ready = 1'b1; @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset during the tenth DIV iteration
        applyStimulus(DIV, 32'hFFFFFFF9, 32'd2);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkReset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        runOp("after reset", ADD, 32'd2, 32'd3, 32'd5, 1);

        // Narrow build
        runOp16("MULHU16", MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
        runOp16("SLL16", SLL, 16'h0001, 16'h0013, 16'h0008, 1);
        runOp16("SRA16", SRA, 16'h8000, 16'h0011, 16'hC000, 1);
        runOp16("DIV16", DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 17);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("results taken", outTaken, mdlTaken);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
